// File: rtl/mul_issue_ctrl.sv
// -----------------------------------------------------------------------------
// mul_issue_ctrl
//
// Queues 32x32 operand pairs and issues them one at a time to an external
// multiplier with a clear/start/done handshake, then holds each 64-bit product
// on a valid/ready output until it is accepted. Results leave in push order.
//
// Optional feature: define MUL_ISSUE_CTRL_TIMEOUT_EN to add a RUN-state
// watchdog. After TIMEOUT_CYC RUN cycles without mul_op_done, the operation
// is aborted and reported with out_result=0, out_err=1. Without the macro,
// RUN waits indefinitely and out_err is tied low.
//
// Ports
//   clk, reset_n                      clock, asynchronous active-low reset
//   in_valid / in_ready               operand-pair input handshake
//   in_multiplier, in_multiplicand    operand pair (32 bits each)
//   mul_multiplier, mul_multiplicand  operands held for the multiplier
//   mul_op_clear                      one-cycle clear pulse before each start
//   mul_op_start                      held high while waiting for done
//   mul_op_done, mul_result           multiplier completion and product
//   out_valid / out_ready             product output handshake
//   out_result, out_err               registered product, timeout flag
//   busy                              FSM not idle or queue non-empty
// -----------------------------------------------------------------------------
module mul_issue_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_multiplier,
  input  logic [31:0] in_multiplicand,
  output logic [31:0] mul_multiplier,
  output logic [31:0] mul_multiplicand,
  output logic        mul_op_start,
  output logic        mul_op_clear,
  input  logic        mul_op_done,
  input  logic [63:0] mul_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic        out_err,
  output logic        busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    OUT  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Operand queue
  // ---------------------------------------------------------------------------
  logic [63:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  state_t           state_q;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // in_ready depends only on occupancy, never on a same-cycle pop, and is
  // forced low while reset is asserted.
  assign in_ready = reset_n && !fifo_full;
  assign push     = in_valid && in_ready;
  // Pop only from IDLE on registered occupancy, so a pair pushed into an
  // empty queue is popped at the following edge at the earliest.
  assign pop      = (state_q == IDLE) && !fifo_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Depth is a power of two, so natural pointer overflow is the wrap.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_multiplier, in_multiplicand};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM with registered outputs
  // ---------------------------------------------------------------------------
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic        clear_q;
  logic        start_q;
  logic        out_valid_q;
  logic [63:0] out_result_q;

`ifdef MUL_ISSUE_CTRL_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] to_cnt_q;
  logic            out_err_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      clear_q      <= 1'b0;
      start_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
`ifdef MUL_ISSUE_CTRL_TIMEOUT_EN
      to_cnt_q     <= '0;
      out_err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            // Head entry is read here; operands stay put until the next pop.
            op_a_q  <= mem_q[rd_ptr_q][63:32];
            op_b_q  <= mem_q[rd_ptr_q][31:0];
            clear_q <= 1'b1;
            state_q <= CLR;
          end
        end
        CLR: begin
          clear_q <= 1'b0;
          start_q <= 1'b1;
          state_q <= RUN;
`ifdef MUL_ISSUE_CTRL_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
        end
        RUN: begin
          if (mul_op_done) begin
            out_result_q <= mul_result;
            start_q      <= 1'b0;
            out_valid_q  <= 1'b1;
            state_q      <= OUT;
`ifdef MUL_ISSUE_CTRL_TIMEOUT_EN
            out_err_q    <= 1'b0;
          end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            // Watchdog abort: report a zero product flagged as an error.
            out_result_q <= '0;
            out_err_q    <= 1'b1;
            start_q      <= 1'b0;
            out_valid_q  <= 1'b1;
            state_q      <= OUT;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
`endif
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
`ifdef MUL_ISSUE_CTRL_TIMEOUT_EN
            out_err_q   <= 1'b0;
`endif
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mul_multiplier   = op_a_q;
  assign mul_multiplicand = op_b_q;
  assign mul_op_clear     = clear_q;
  assign mul_op_start     = start_q;
  assign out_valid        = out_valid_q;
  assign out_result       = out_result_q;
  assign busy             = (state_q != IDLE) || !fifo_empty;

`ifdef MUL_ISSUE_CTRL_TIMEOUT_EN
  assign out_err = out_err_q;
`else
  // No watchdog in this build: out_err is constant 0 for any legal limit.
  assign out_err = (TIMEOUT_CYC < 0);
`endif

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul_issue_ctrl
//
// Directed-vector bench for mul_issue_ctrl. Stimulus pushes hand-computed
// expected products into a scoreboard queue; a monitor pops and compares on
// every output handshake and also watches the clear/start sequencing.
// A behavioural multiplier with programmable latency (and a "hang" mode)
// drives mul_op_done / mul_result.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mul_issue_ctrl;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_multiplier;
  logic [31:0] in_multiplicand;
  logic [31:0] mul_multiplier;
  logic [31:0] mul_multiplicand;
  logic        mul_op_start;
  logic        mul_op_clear;
  logic        mul_op_done;
  logic [63:0] mul_result;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic        out_err;
  logic        busy;

  mul_issue_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYC(64)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_multiplier    (in_multiplier),
    .in_multiplicand  (in_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_multiplicand (mul_multiplicand),
    .mul_op_start     (mul_op_start),
    .mul_op_clear     (mul_op_clear),
    .mul_op_done      (mul_op_done),
    .mul_result       (mul_result),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_err          (out_err),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          n_out = 0;
  logic [64:0] sb [$];   // {err, result}

  task automatic check(input string nm, input logic [64:0] act, input logic [64:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural multiplier
  // ---------------------------------------------------------------------------
  int   mdl_lat  = 3;
  int   mdl_cnt  = 0;
  logic mdl_hang = 1'b0;

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mul_op_done = 1'b0;
      mul_result  = '0;
      mdl_cnt     = 0;
    end else if (mul_op_clear) begin
      mul_op_done = 1'b0;
      mdl_cnt     = 0;
    end else if (mul_op_start && !mul_op_done && !mdl_hang) begin
      mdl_cnt++;
      if (mdl_cnt >= mdl_lat) begin
        mul_op_done = 1'b1;
        mul_result  = 64'(mul_multiplier) * 64'(mul_multiplicand);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: scoreboard compare plus clear/start sequencing
  // ---------------------------------------------------------------------------
  logic prev_clear = 1'b0;
  logic prev_start = 1'b0;
  logic prev_valid = 1'b0;
  int   run_len    = 0;
  int   last_run   = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_clear)
        check("clear_pulse_width", {64'b0, mul_op_clear}, 65'd0);
      if (mul_op_start && !prev_start) begin
        check("clear_before_start", {64'b0, prev_clear}, 65'd1);
        run_len = 0;
      end
      if (mul_op_start) run_len++;
      if (out_valid && !prev_valid) last_run = run_len;
      if (out_valid && out_ready) begin
        n_out++;
        $display("[TB] out #%0d result=0x%016h err=%0b", n_out, out_result, out_err);
        if (sb.size() == 0) begin
          check("unexpected_out", {1'b1, 64'b0}, {1'b0, 64'b0});
        end else begin
          logic [64:0] exp;
          exp = sb.pop_front();
          check("out_result", {1'b0, out_result}, {1'b0, exp[63:0]});
          check("out_err", {64'b0, out_err}, {64'b0, exp[64]});
        end
      end
      prev_clear = mul_op_clear;
      prev_start = mul_op_start;
      prev_valid = out_valid;
    end else begin
      prev_clear = 1'b0;
      prev_start = 1'b0;
      prev_valid = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at posedge+#1)
  // ---------------------------------------------------------------------------
  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic [64:0] exp, output int waited);
    logic ok;
    ok = 1'b0;
    waited = 0;
    in_valid        = 1'b1;
    in_multiplier   = a;
    in_multiplicand = b;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(exp);
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      waited++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    $display("[TB] push 0x%08h x 0x%08h waited=%0d", a, b, waited);
    if (!ok) check("push_timeout", 65'd0, 65'd1);
  endtask

  task automatic wait_start();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mul_op_start) begin ok = 1'b1; break; end
    end
    check("wait_start", {64'b0, ok}, 65'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    check("wait_valid", {64'b0, ok}, 65'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && !out_valid) begin ok = 1'b1; break; end
    end
    check("drain", {64'b0, ok}, 65'd1);
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int w;
    int n0;
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_multiplier = '0;
    in_multiplicand = '0;
    out_ready = 1'b0;
    #3;
    check("rst_out_valid", {64'b0, out_valid},    65'd0);
    check("rst_in_ready",  {64'b0, in_ready},     65'd0);
    check("rst_busy",      {64'b0, busy},         65'd0);
    check("rst_start",     {64'b0, mul_op_start}, 65'd0);
    check("rst_clear",     {64'b0, mul_op_clear}, 65'd0);
    check("rst_err",       {64'b0, out_err},      65'd0);
    check("rst_result",    {1'b0, out_result},    65'd0);
    check("rst_mul_a",     {33'b0, mul_multiplier}, 65'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post_rst_in_ready", {64'b0, in_ready}, 65'd1);
    @(posedge clk); #1;

    // Basic product with out_ready high.
    out_ready = 1'b1;
    mdl_lat = 3;
    push(32'h0000_0101, 32'h0000_784B, {1'b0, 64'h0000_0000_0078_C34B}, w);
    drain();

    // All-ones operands.
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 64'hFFFF_FFFE_0000_0001}, w);
    drain();

    // Fill the queue while one operation is running.
    mdl_lat = 8;
    n0 = n_out;
    push(32'h0001_0000, 32'h0001_0000, {1'b0, 64'h0000_0001_0000_0000}, w);
    wait_start();
    push(32'd2,  32'd3,  {1'b0, 64'd6},   w);
    push(32'd4,  32'd5,  {1'b0, 64'h14},  w);
    push(32'd7,  32'd9,  {1'b0, 64'h3F},  w);
    push(32'h10, 32'h10, {1'b0, 64'h100}, w);
    check("full_in_ready", {64'b0, in_ready}, 65'd0);
    push(32'h1000, 32'h1000, {1'b0, 64'h0100_0000}, w);
    check("fifth_stalled", {64'b0, (w > 0)}, 65'd1);
    drain();
    check("six_results", 65'(n_out - n0), 65'd6);

    // Back-pressure: hold out_ready low for 20 cycles.
    mdl_lat = 3;
    out_ready = 1'b0;
    n0 = n_out;
    push(32'd7, 32'd9, {1'b0, 64'h3F}, w);
    wait_valid();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_valid",  {64'b0, out_valid},    65'd1);
      check("hold_result", {1'b0, out_result},    65'h3F);
      check("hold_start",  {64'b0, mul_op_start}, 65'd0);
      check("hold_busy",   {64'b0, busy},         65'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("one_handshake", 65'(n_out - n0), 65'd1);

    // Reset mid-RUN with three pairs queued.
    mdl_hang = 1'b1;
    push(32'd11, 32'd13, {1'b0, 64'd143}, w);
    wait_start();
    push(32'd1, 32'd1, {1'b0, 64'd1}, w);
    push(32'd2, 32'd2, {1'b0, 64'd4}, w);
    push(32'd3, 32'd3, {1'b0, 64'd9}, w);
    #2;
    reset_n = 1'b0;
    #1;
    sb.delete();
    mdl_hang = 1'b0;
    check("mid_rst_start",  {64'b0, mul_op_start}, 65'd0);
    check("mid_rst_clear",  {64'b0, mul_op_clear}, 65'd0);
    check("mid_rst_valid",  {64'b0, out_valid},    65'd0);
    check("mid_rst_busy",   {64'b0, busy},         65'd0);
    check("mid_rst_ready",  {64'b0, in_ready},     65'd0);
    check("mid_rst_result", {1'b0, out_result},    65'd0);
    check("mid_rst_mul_b",  {33'b0, mul_multiplicand}, 65'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rel_in_ready", {64'b0, in_ready}, 65'd1);
    check("rel_busy",     {64'b0, busy},     65'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_stale_valid", {64'b0, out_valid}, 65'd0);
    end
    @(posedge clk); #1;
    push(32'd3, 32'd5, {1'b0, 64'hF}, w);
    drain();

`ifdef MUL_ISSUE_CTRL_TIMEOUT_EN
    // Watchdog: first op never completes, the queued one runs normally.
    mdl_hang = 1'b1;
    push(32'd6, 32'd7, {1'b1, 64'd0}, w);
    push(32'd2, 32'd3, {1'b0, 64'd6}, w);
    wait_valid();
    mdl_hang = 1'b0;
    check("timeout_run_cycles", 65'(last_run), 65'd64);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/mul_issue_ctrl.md
MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, 4, operand-pair queue entries (power of two, >=2).
REQ-002 Parameter TIMEOUT_CYC, 64, RUN-state cycle limit (used only under REQ-030).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  queue can accept a pair.
REQ-007 in_multiplier  input  32  operand A.
REQ-008 in_multiplicand  input  32  operand B.
REQ-009 mul_multiplier / mul_multiplicand  output  32 each  operands driven to the multiplier.
REQ-010 mul_op_start  output  1  multiplier start, held high for the whole operation.
REQ-011 mul_op_clear  output  1  multiplier clear pulse.
REQ-012 mul_op_done  input  1  multiplier finished; held high until cleared.
REQ-013 mul_result  input  64  multiplier product.
REQ-014 out_valid  output  1  product available.
REQ-015 out_ready  input  1  consumer accepts product.
REQ-016 out_result  output  64  registered product.
REQ-017 out_err  output  1  product produced by timeout abort.
REQ-018 busy  output  1  high when state != IDLE or the queue is non-empty.

Function
REQ-019 Queue: in-order FIFO of FIFO_DEPTH pairs; push on in_valid&&in_ready; in_ready = !full, with no dependence on a same-cycle pop.
REQ-020 No bypass: a pair pushed into an empty queue is popped no earlier than the next edge.
REQ-021 FSM states are IDLE, CLR, RUN and OUT.
  - IDLE: if the queue is non-empty, pop the head into the operand registers and go to CLR.
  - CLR: mul_op_clear=1 for exactly one cycle, then RUN.
  - RUN: mul_op_start=1 until mul_op_done is sampled high.
  - OUT: out_valid=1, mul_op_start=0; on out_ready, go to IDLE.
REQ-022 mul_multiplier and mul_multiplicand are stable from CLR entry until the next IDLE->CLR transition.
REQ-023 At the edge where RUN samples mul_op_done=1: out_result<=mul_result, out_err<=0, state<=OUT. out_valid is high in the following cycle.
REQ-024 Latency: an entry popped at edge e0 has mul_op_clear high during e0..e1 and mul_op_start high from e1.
REQ-025 out_valid stays high and out_result stays unchanged until out_ready is sampled high; the handshake is never dropped.
REQ-026 mul_op_done high in IDLE, CLR or OUT is ignored.
REQ-027 Push while full is impossible (in_ready=0). Push and pop in the same cycle leave the occupancy unchanged. Pointers wrap modulo FIFO_DEPTH.
REQ-028 Results leave in push order; one operation is outstanding at a time.

Reset
REQ-029 While reset_n=0 (asynchronously):
  - state = IDLE, queue empty, operand registers = 0.
  - out_result = 0; out_valid, out_err, mul_op_start, mul_op_clear, busy = 0.
  - in_ready = 0 during reset and 1 after release.
  - Reset mid-operation discards the in-flight operation and all queued pairs.

Configuration
REQ-030 Macro MUL_ISSUE_CTRL_TIMEOUT_EN selects the timeout watchdog.
  - Defined: a counter clears on RUN entry and increments each RUN cycle. If it reaches TIMEOUT_CYC-1 without mul_op_done, go to OUT with out_result=0 and out_err=1; out_err clears on the out handshake.
  - Undefined: RUN waits indefinitely, out_err is constant 0, and no counter logic is present.

Verification
REQ-031 Push 0x0000_0101 x 0x0000_784B, out_ready=1 -> one out_valid with out_result=64'h0000_0000_0078_C34B, out_err=0; mul_op_clear pulses exactly one cycle before mul_op_start rises.
REQ-032 Push 5 pairs back-to-back while the first is running -> in_ready falls after 4 accepted; the 5th is accepted after the first pop; 5 results arrive in push order.
REQ-033 Hold out_ready=0 for 20 cycles after out_valid -> out_valid and out_result stay stable, mul_op_start=0, busy=1; release yields one handshake.
REQ-034 Push 0xFFFF_FFFF x 0xFFFF_FFFF -> out_result=64'hFFFF_FFFE_0000_0001.
REQ-035 Assert reset_n=0 mid-RUN with 3 pairs queued -> all outputs 0 immediately; after release in_ready=1, busy=0, and no stale out_valid.
REQ-036 With MUL_ISSUE_CTRL_TIMEOUT_EN defined, multiplier model never raises mul_op_done -> out_valid after 64 RUN cycles with out_result=0 and out_err=1; the next queued pair then runs normally.
